// File: rtl/seq_alu.sv
// Registered WIDTH-bit ALU with valid/ready input handshake and a multi-cycle shift-add multiply.
// Define SEQ_ALU_OVF_FLAGS_EN to add the registered Ovf/Neg outputs.
module seq_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OpCode,
    input  logic             LogicMode,
    output logic             out_valid,
    output logic [WIDTH-1:0] Result,
    output logic             C_out,
`ifdef SEQ_ALU_OVF_FLAGS_EN
    output logic             Zero,
    output logic             Ovf,
    output logic             Neg
`else
    output logic             Zero
`endif
);

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mul_acc;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 c_q, c_d;
    logic                 zero_q, zero_d;
    logic                 out_valid_q, out_valid_d;

    logic                 accept;
    logic                 is_mul;
    logic [WIDTH-1:0]     logic_res;
    logic [WIDTH-1:0]     add_x, add_y, add_y_eff;
    logic                 add_sub;
    logic [WIDTH:0]       sum;

    assign in_ready = (state_q == StIdle);
    assign accept   = in_valid & in_ready;
    assign is_mul   = LogicMode & (OpCode == 3'b100);

    always_comb begin
        logic_res = '0;
        unique case (OpCode)
            3'b000: logic_res = A & B;
            3'b001: logic_res = A | B;
            3'b010: logic_res = ~(A & B);
            3'b011: logic_res = ~(A | B);
            3'b100: logic_res = A ^ B;
            3'b101: logic_res = ~(A ^ B);
            3'b110: logic_res = ~A;
            3'b111: logic_res = ~B;
            default: logic_res = '0;
        endcase
    end

    // Every arithmetic op maps onto x + y or x - y; subtract is x + ~y + 1 so the carry
    // out doubles as the no-borrow flag.
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_sub = 1'b0;
        unique case (OpCode)
            3'b000: begin add_y = A; add_sub = 1'b1; end
            3'b001: begin add_y = B; add_sub = 1'b1; end
            3'b010: begin add_x = A; add_y = B; end
            3'b011: begin add_x = A; add_y = B; add_sub = 1'b1; end
            3'b101: begin add_x = B; add_y = A; add_sub = 1'b1; end
            3'b110: begin add_x = A; add_y = WIDTH'(1); end
            3'b111: begin add_x = A; add_y = WIDTH'(1); add_sub = 1'b1; end
            default: ;
        endcase
    end

    assign add_y_eff = add_sub ? ~add_y : add_y;
    assign sum       = {1'b0, add_x} + {1'b0, add_y_eff} + {{WIDTH{1'b0}}, add_sub};
    assign mul_acc   = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        result_d    = result_q;
        c_d         = c_q;
        out_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d  = StMul;
                        cnt_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, A};
                        mplier_d = B;
                        acc_d    = '0;
                    end else begin
                        result_d    = LogicMode ? sum[WIDTH-1:0] : logic_res;
                        c_d         = LogicMode & sum[WIDTH];
                        out_valid_d = 1'b1;
                    end
                end
            end
            StMul: begin
                acc_d    = mul_acc;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LastStep) begin
                    state_d     = StIdle;
                    result_d    = mul_acc[WIDTH-1:0];
                    c_d         = |mul_acc[2*WIDTH-1:WIDTH];
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        zero_d = out_valid_d ? (result_d == '0) : zero_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            c_q         <= 1'b0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            c_q         <= c_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign Result    = result_q;
    assign C_out     = c_q;
    assign Zero      = zero_q;

`ifdef SEQ_ALU_OVF_FLAGS_EN
    logic add_ovf;
    logic ovf_q;

    assign add_ovf = (add_x[WIDTH-1] == add_y_eff[WIDTH-1]) &&
                     (sum[WIDTH-1] != add_x[WIDTH-1]);

    // Only single-cycle arithmetic completions can overflow; multiply completes from StMul.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (out_valid_d) begin
            ovf_q <= (state_q == StIdle) & LogicMode & add_ovf;
        end
    end

    assign Ovf = ovf_q;
    assign Neg = result_q[WIDTH-1];
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed vectors plus randomized ops against an
// arithmetic reference model.
module tb_seq_alu;

    localparam int unsigned W = 8;
    localparam longint M = 256;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   op_code = '0;
    logic         logic_mode = 1'b0;
    logic         out_valid;
    logic [W-1:0] result;
    logic         c_out;
    logic         zero;
`ifdef SEQ_ALU_OVF_FLAGS_EN
    logic         ovf;
    logic         neg;
`endif

    int checks = 0;
    int failures = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .OpCode    (op_code),
        .LogicMode (logic_mode),
        .out_valid (out_valid),
        .Result    (result),
        .C_out     (c_out),
`ifdef SEQ_ALU_OVF_FLAGS_EN
        .Zero      (zero),
        .Ovf       (ovf),
        .Neg       (neg)
`else
        .Zero      (zero)
`endif
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the unsigned operand values.
    function automatic void ref_op(input longint x, input longint y, input logic [2:0] op,
                                   input logic lm, output longint r, output bit c);
        longint full;
        c = 1'b0;
        full = 0;
        if (!lm) begin
            case (op)
                3'd0: full = x & y;
                3'd1: full = x | y;
                3'd2: full = ~(x & y);
                3'd3: full = ~(x | y);
                3'd4: full = x ^ y;
                3'd5: full = ~(x ^ y);
                3'd6: full = ~x;
                default: full = ~y;
            endcase
        end else begin
            case (op)
                3'd0: begin full = M - x;     c = (x == 0);  end
                3'd1: begin full = M - y;     c = (y == 0);  end
                3'd2: begin full = x + y;     c = (full >= M); end
                3'd3: begin full = M + x - y; c = (x >= y);  end
                3'd4: begin full = x * y;     c = (full >= M); end
                3'd5: begin full = M + y - x; c = (y >= x);  end
                3'd6: begin full = x + 1;     c = (full >= M); end
                default: begin full = M + x - 1; c = (x >= 1); end
            endcase
        end
        r = full & (M - 1);
    endfunction

    // Presents one operation for exactly one rising edge; returns 1 ns after that edge.
    task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] op,
                         input logic lm);
        @(negedge clk);
        a = x; b = y; op_code = op; logic_mode = lm; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks += 5;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        if (result !== 8'h00) begin failures++; $display("FAIL reset_result got=%h exp=00", result); end
        if (c_out !== 1'b0) begin failures++; $display("FAIL reset_c_out got=%b exp=0", c_out); end
        if (zero !== 1'b1) begin failures++; $display("FAIL reset_zero got=%b exp=1", zero); end
        drive(8'hF0, 8'h20, 3'b010, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checks += 5;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL async_rst_in_ready got=%b exp=1", in_ready); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL async_rst_out_valid got=%b exp=0", out_valid); end
        if (result !== 8'h00) begin failures++; $display("FAIL async_rst_result got=%h exp=00", result); end
        if (c_out !== 1'b0) begin failures++; $display("FAIL async_rst_c_out got=%b exp=0", c_out); end
        if (zero !== 1'b1) begin failures++; $display("FAIL async_rst_zero got=%b exp=1", zero); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        drive(8'hF0, 8'h20, 3'b010, 1'b1);
        checks += 3;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_add_valid got=%b exp=1", out_valid); end
        if (result !== 8'h10) begin failures++; $display("FAIL b2b_add_result got=%h exp=10", result); end
        if (c_out !== 1'b1) begin failures++; $display("FAIL b2b_add_c_out got=%b exp=1", c_out); end
        drive(8'h05, 8'h07, 3'b011, 1'b1);
        checks += 3;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_sub_valid got=%b exp=1", out_valid); end
        if (result !== 8'hFE) begin failures++; $display("FAIL b2b_sub_result got=%h exp=fe", result); end
        if (c_out !== 1'b0) begin failures++; $display("FAIL b2b_sub_c_out got=%b exp=0", c_out); end
        @(posedge clk);
        #1;
        checks += 2;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_pulse got=%b exp=0", out_valid); end
        if (result !== 8'hFE) begin failures++; $display("FAIL b2b_hold got=%h exp=fe", result); end
    endtask

    task automatic test_logic();
        drive(8'hA5, 8'h5A, 3'b011, 1'b0);
        checks += 4;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL logic_valid got=%b exp=1", out_valid); end
        if (result !== 8'h00) begin failures++; $display("FAIL logic_result got=%h exp=00", result); end
        if (zero !== 1'b1) begin failures++; $display("FAIL logic_zero got=%b exp=1", zero); end
        if (c_out !== 1'b0) begin failures++; $display("FAIL logic_c_out got=%b exp=0", c_out); end
    endtask

    task automatic test_multiply();
        int lat;
        int busy_bad;
        drive(8'h13, 8'h11, 3'b100, 1'b1);
        // Offer a competing add throughout MUL; it must be ignored.
        a = 8'h01; b = 8'h01; op_code = 3'b010; in_valid = 1'b1;
        lat = 0;
        busy_bad = 0;
        while (out_valid !== 1'b1 && lat < W + 4) begin
            if (in_ready !== 1'b0) busy_bad++;
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        checks += 6;
        if (lat != W) begin failures++; $display("FAIL mul_latency got=%0d exp=%0d", lat, W); end
        if (busy_bad != 0) begin failures++; $display("FAIL mul_in_ready_low got=%0d high cycles exp=0", busy_bad); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL mul_done_ready got=%b exp=1", in_ready); end
        if (result !== 8'h43) begin failures++; $display("FAIL mul_result got=%h exp=43", result); end
        if (c_out !== 1'b1) begin failures++; $display("FAIL mul_c_out got=%b exp=1", c_out); end
        if (zero !== 1'b0) begin failures++; $display("FAIL mul_zero got=%b exp=0", zero); end
        @(posedge clk);
        #1;
        checks += 2;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL mul_ignored_valid got=%b exp=0", out_valid); end
        if (result !== 8'h43) begin failures++; $display("FAIL mul_ignored_result got=%h exp=43", result); end
    endtask

    task automatic test_reset_mid_mul();
        int spurious;
        drive(8'h13, 8'h11, 3'b100, 1'b1);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks += 2;
        if (result !== 8'h00) begin failures++; $display("FAIL midmul_rst_result got=%h exp=00", result); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL midmul_rst_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        spurious = 0;
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) spurious++;
        end
        checks += 1;
        if (spurious != 0) begin failures++; $display("FAIL midmul_no_valid got=%0d pulses exp=0", spurious); end
        drive(8'h22, 8'h11, 3'b010, 1'b1);
        checks += 2;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL midmul_next_valid got=%b exp=1", out_valid); end
        if (result !== 8'h33) begin failures++; $display("FAIL midmul_next_result got=%h exp=33", result); end
    endtask

    task automatic test_random();
        longint er;
        bit ec;
        int lat;
        int exp_lat;
        logic [W-1:0] x, y;
        logic [2:0] op;
        logic lm;
        for (int n = 0; n < 60; n++) begin
            x = W'($urandom);
            y = W'($urandom);
            if (n % 7 == 0) y = '0;
            if (n % 11 == 0) x = 8'hFF;
            op = 3'($urandom_range(0, 7));
            lm = 1'($urandom);
            ref_op(longint'(x), longint'(y), op, lm, er, ec);
            exp_lat = (lm && op == 3'd4) ? W : 0;
            drive(x, y, op, lm);
            lat = 0;
            while (out_valid !== 1'b1 && lat < W + 4) begin
                @(posedge clk);
                #1;
                lat++;
            end
            checks += 4;
            if (lat != exp_lat) begin failures++; $display("FAIL rand_latency lm=%b op=%0d got=%0d exp=%0d", lm, op, lat, exp_lat); end
            if (longint'(result) != er) begin failures++; $display("FAIL rand_result lm=%b op=%0d a=%h b=%h got=%h exp=%h", lm, op, x, y, result, er); end
            if (c_out !== ec) begin failures++; $display("FAIL rand_c_out lm=%b op=%0d a=%h b=%h got=%b exp=%b", lm, op, x, y, c_out, ec); end
            if (zero !== (er == 0)) begin failures++; $display("FAIL rand_zero lm=%b op=%0d got=%b exp=%b", lm, op, zero, er == 0); end
        end
    endtask

`ifdef SEQ_ALU_OVF_FLAGS_EN
    task automatic test_ovf();
        drive(8'h7F, 8'h01, 3'b010, 1'b1);
        checks += 4;
        if (result !== 8'h80) begin failures++; $display("FAIL ovf_result got=%h exp=80", result); end
        if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
        if (neg !== 1'b1) begin failures++; $display("FAIL ovf_neg got=%b exp=1", neg); end
        if (c_out !== 1'b0) begin failures++; $display("FAIL ovf_c_out got=%b exp=0", c_out); end
    endtask
`endif

    initial begin
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_back_to_back();
        test_logic();
        test_multiply();
        test_reset_mid_mul();
        test_random();
`ifdef SEQ_ALU_OVF_FLAGS_EN
        test_ovf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
